// File: rtl/pipeline_elastic_stage.sv
// pipeline_elastic_stage
//
// Elastic valid/ready register stage. It carries one packed payload bus between two pipeline
// stages and holds up to DEPTH entries in a small circular buffer. in_ready and out_valid are
// decoded from registered occupancy only, so no combinational path runs from out_ready to
// in_ready. A synchronous flush squashes every held entry. out_data reads as an all-zero bubble
// whenever out_valid is low.
//
// Legacy stall mapping:
//   stall_next_stage        -> out_ready = 0
//   stall of current stage  -> in_valid  = 0
//   bubble                  -> out_valid = 0, out_data = 0
//
// Optional build macro:
//   PIPE_ELASTIC_PERF_EN adds the backpressure_cycles and full_cycles counters. Both are
//   32 bits wide and saturating. rst clears them. flush does not.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous active-high reset
//   flush                synchronous squash of all held entries (highest priority)
//   in_valid/in_ready    upstream handshake
//   in_data              upstream payload
//   out_valid/out_ready  downstream handshake
//   out_data             head payload, zero when out_valid = 0
//   occupancy            number of held entries, 0..DEPTH
//   backpressure_cycles  (PIPE_ELASTIC_PERF_EN) cycles with out_valid=1 and out_ready=0
//   full_cycles          (PIPE_ELASTIC_PERF_EN) cycles with the stage full
module pipeline_elastic_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  occupancy
`ifdef PIPE_ELASTIC_PERF_EN
  ,
  output logic [31:0]           backpressure_cycles,
  output logic [31:0]           full_cycles
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam logic [PtrW-1:0]      PtrLast = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0]      PtrOne  = PtrW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  in_fire, out_fire;

  // Handshake outputs come from registered state only.
  always_comb begin
    in_ready  = (count_q != CntFull);
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    occupancy = count_q;
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next state. Pointers wrap by explicit compare because DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (in_fire) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
      end
      if (out_fire) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
      end
      unique case ({in_fire, out_fire})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage. Vacated and flushed entries are left as they are because out_data is masked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (in_fire && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef PIPE_ELASTIC_PERF_EN
  logic [31:0] bp_cnt_q, bp_cnt_d;
  logic [31:0] full_cnt_q, full_cnt_d;

  always_comb begin
    bp_cnt_d   = bp_cnt_q;
    full_cnt_d = full_cnt_q;
    if (out_valid && !out_ready && (bp_cnt_q != 32'hFFFF_FFFF)) begin
      bp_cnt_d = bp_cnt_q + 32'd1;
    end
    if ((count_q == CntFull) && (full_cnt_q != 32'hFFFF_FFFF)) begin
      full_cnt_d = full_cnt_q + 32'd1;
    end
  end

  // flush deliberately does not clear these counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_cnt_q   <= '0;
      full_cnt_q <= '0;
    end else begin
      bp_cnt_q   <= bp_cnt_d;
      full_cnt_q <= full_cnt_d;
    end
  end

  assign backpressure_cycles = bp_cnt_q;
  assign full_cycles         = full_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// Self-checking bench for pipeline_elastic_stage. Three instances run side by side with
// DEPTH = 2, 3 and 4. Each instance is compared every cycle against a queue-based model.
module tb_pipeline_elastic_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int N = 3;

  logic          clk;
  logic          rst;
  logic          flush     [N];
  logic          in_valid  [N];
  logic          in_ready  [N];
  logic [DW-1:0] in_data   [N];
  logic          out_valid [N];
  logic          out_ready [N];
  logic [DW-1:0] out_data  [N];
  logic [CW-1:0] occupancy [N];
`ifdef PIPE_ELASTIC_PERF_EN
  logic [31:0]   bp_cyc    [N];
  logic [31:0]   full_cyc  [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipeline_elastic_stage #(
      .DATA_WIDTH(DW),
      .DEPTH     (g + 2),
      .CNT_WIDTH (CW)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .occupancy(occupancy[g])
`ifdef PIPE_ELASTIC_PERF_EN
      ,
      .backpressure_cycles(bp_cyc[g]),
      .full_cycles        (full_cyc[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one FIFO queue per instance, plus perf counters.
  logic [DW-1:0] q0[$], q1[$], q2[$];
  logic [31:0]   bp_m   [N];
  logic [31:0]   full_m [N];
  bit            acc    [N];
  int            xfers1;

  function automatic int depth_of(input int i);
    return i + 2;
  endfunction

  function automatic int msize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] mhead(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic mpush(input int i, input logic [DW-1:0] d);
    case (i)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic mpop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic mclear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic set_idle();
    for (int i = 0; i < N; i++) begin
      flush[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
  endtask

  // Check all outputs against the model, cross one clock edge, then update the model.
  task automatic step();
    bit inf [N];
    bit outf [N];
    for (int i = 0; i < N; i++) begin
      int sz;
      logic [DW-1:0] exp_d;
      sz    = msize(i);
      exp_d = (sz != 0) ? mhead(i) : '0;
      check_eq($sformatf("d%0d out_valid", i), 64'(out_valid[i]), 64'(sz != 0));
      check_eq($sformatf("d%0d out_data", i), 64'(out_data[i]), 64'(exp_d));
      check_eq($sformatf("d%0d occupancy", i), 64'(occupancy[i]), 64'(sz));
      check_eq($sformatf("d%0d in_ready", i), 64'(in_ready[i]), 64'(sz != depth_of(i)));
`ifdef PIPE_ELASTIC_PERF_EN
      check_eq($sformatf("d%0d bp_cycles", i), 64'(bp_cyc[i]), 64'(bp_m[i]));
      check_eq($sformatf("d%0d full_cycles", i), 64'(full_cyc[i]), 64'(full_m[i]));
`endif
      inf[i]  = in_valid[i] && (sz != depth_of(i));
      outf[i] = out_ready[i] && (sz != 0);
      if (sz != 0 && !out_ready[i] && bp_m[i] != 32'hFFFF_FFFF) bp_m[i]++;
      if (sz == depth_of(i) && full_m[i] != 32'hFFFF_FFFF) full_m[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      acc[i] = inf[i];
      if (flush[i]) begin
        mclear(i);
      end else begin
        if (outf[i]) mpop(i);
        if (inf[i]) mpush(i, in_data[i]);
        if (i == 1 && outf[i]) xfers1++;
      end
    end
  endtask

  // Assert reset between clock edges and confirm the outputs clear before the next edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("d%0d rst out_valid", i), 64'(out_valid[i]), 64'd0);
      check_eq($sformatf("d%0d rst out_data", i), 64'(out_data[i]), 64'd0);
      check_eq($sformatf("d%0d rst occupancy", i), 64'(occupancy[i]), 64'd0);
      check_eq($sformatf("d%0d rst in_ready", i), 64'(in_ready[i]), 64'd1);
`ifdef PIPE_ELASTIC_PERF_EN
      check_eq($sformatf("d%0d rst bp_cycles", i), 64'(bp_cyc[i]), 64'd0);
      check_eq($sformatf("d%0d rst full_cycles", i), 64'(full_cyc[i]), 64'd0);
`endif
      mclear(i);
      bp_m[i]   = '0;
      full_m[i] = '0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] val;
    xfers1 = 0;
    set_idle();
    for (int i = 0; i < N; i++) begin
      bp_m[i]   = '0;
      full_m[i] = '0;
      acc[i]    = 1'b0;
    end

    // Reset held for two cycles, then idle.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();

    // Single transfer through the DEPTH=2 instance.
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'hDEAD_BEEF;
    out_ready[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    check_eq("single out_data", 64'(out_data[0]), 64'h0000_0000_DEAD_BEEF);
    step();
    step();

    // Backpressure fill of the DEPTH=4 instance with values 1..5.
    val = 32'd1;
    out_ready[2] = 1'b0;
    repeat (6) begin
      in_valid[2] = 1'b1;
      in_data[2]  = val;
      step();
      if (acc[2]) val++;
    end
    check_eq("fill occupancy", 64'(occupancy[2]), 64'd4);
    check_eq("fill in_ready", 64'(in_ready[2]), 64'd0);
    check_eq("fill held value", 64'(val), 64'd5);
    out_ready[2] = 1'b1;
    repeat (12) begin
      in_valid[2] = (val <= 32'd5);
      in_data[2]  = val;
      step();
      if (acc[2]) val++;
    end
    check_eq("drain done", 64'(occupancy[2]), 64'd0);
    set_idle();

    // Flush while full, with a concurrent input.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'h1111_1111;
    step();
    in_data[0] = 32'h2222_2222;
    step();
    check_eq("preflush occupancy", 64'(occupancy[0]), 64'd2);
    flush[0]     = 1'b1;
    in_data[0]   = 32'h3333_3333;
    out_ready[0] = 1'b1;
    step();
    set_idle();
    check_eq("flush occupancy", 64'(occupancy[0]), 64'd0);
    check_eq("flush out_valid", 64'(out_valid[0]), 64'd0);
    check_eq("flush in_ready", 64'(in_ready[0]), 64'd1);
    step();
    step();

    // Random traffic with occasional flushes on every instance.
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = 1'($urandom_range(0, 1));
        in_data[i]   = $urandom;
        out_ready[i] = ($urandom_range(0, 3) != 0);
        flush[i]     = ($urandom_range(0, 63) == 0);
      end
      step();
    end
    set_idle();
    check_eq("random xfers>=200", 64'(xfers1 >= 200), 64'd1);
    step();

    // Async reset mid-stream after a seven-cycle stall.
    async_reset();
    out_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = $urandom;
      step();
    end
    in_valid[1] = 1'b0;
    repeat (5) step();
    check_eq("stall occupancy", 64'(occupancy[1]), 64'd3);
`ifdef PIPE_ELASTIC_PERF_EN
    check_eq("stall bp_cycles", 64'(bp_cyc[1]), 64'd7);
`endif
    async_reset();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic_stage.md
Name: pipeline_elastic_stage

Overview:
Parametrised successor to the fixed MEM/WB stall-driven register bank. It carries one packed payload bus between two pipeline stages using a valid/ready handshake. Storage is DEPTH entries, so the upstream stage can keep issuing while downstream is stalled, with no combinational ready path. The stage also provides a synchronous flush for exception/branch squash, and out_data reads as a zero bubble whenever out_valid is low.

Parameters:
DATA_WIDTH, 32, width of the packed payload bus (result, flags, addresses concatenated by the instantiating stage)
DEPTH, 2, number of payload entries; legal range 2..16; not required to be a power of two
CNT_WIDTH, 5, width of occupancy count; must satisfy 2^CNT_WIDTH > DEPTH

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept a payload this cycle
in_data  input  DATA_WIDTH  upstream payload
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head this cycle
out_data  output  DATA_WIDTH  head payload; all-zero when out_valid=0
occupancy  output  CNT_WIDTH  number of held entries, 0..DEPTH

Behaviour:
- Reset (async, active-high): count=0, write pointer=0, read pointer=0, all storage entries=0. Outputs: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (count != DEPTH). It is a function of registered state only and never depends on out_ready.
- out_valid = (count != 0).
- out_data = storage[rd_ptr] when out_valid=1, else all zeros (bubble, matches legacy reset/bubble value).
- Latency: a payload accepted into an empty stage appears on out_valid/out_data exactly one cycle after in_fire. There is no same-cycle bypass.
- Throughput: one transfer per cycle sustained when in_valid=out_ready=1 at any occupancy from 1 to DEPTH-1.
- Pointers: wr_ptr advances on in_fire and rd_ptr advances on out_fire. Each wraps from DEPTH-1 to 0 (explicit compare, no modulo on non-power-of-two DEPTH).
- Count update:
  - in_fire only: +1
  - out_fire only: -1
  - both: unchanged
  - neither: unchanged
- Full (count=DEPTH): in_ready=0, in_data is ignored. A simultaneous out_fire frees a slot, but in_ready stays 0 in that cycle; the slot becomes usable next cycle.
- Empty (count=0): out_fire is impossible. out_ready is ignored.
- Flush (highest priority, synchronous):
  - On a clock edge with flush=1: count=0, rd_ptr=wr_ptr=0. Any in_fire or out_fire in that cycle is discarded.
  - Next cycle: out_valid=0, occupancy=0, in_ready=1.
  - Storage contents need not be cleared; out_data is masked by out_valid.
- Entries vacated by out_fire need not be cleared, for the same reason.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), regardless of flush, in_valid or out_ready.
- Legacy stall mapping, documented for integrators:
  - stall_next_stage corresponds to out_ready=0.
  - A stall of the current stage corresponds to in_valid=0 from upstream.
  - A bubble is out_valid=0 with out_data=0.

Optional Feature:
Macro: PIPE_ELASTIC_PERF_EN
- With the macro defined, two extra outputs are added:
  - backpressure_cycles (32-bit): increments on each cycle with out_valid=1 and out_ready=0.
  - full_cycles (32-bit): increments on each cycle with count=DEPTH.
- Both counters reset to 0 on rst, saturate at 32'hFFFFFFFF, and are not cleared by flush.
- Without the macro, these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, release -> out_valid=0, out_data=0, occupancy=0, in_ready=1 every cycle.
2. Single transfer: DEPTH=2, send 32'hDEADBEEF with out_ready=1 -> out_valid=1, out_data=32'hDEADBEEF on the next cycle only, then out_valid=0, out_data=0.
3. Backpressure fill: DEPTH=4, out_ready=0, stream 1,2,3,4,5 -> in_ready falls after 4 accepts, occupancy=4, value 5 held upstream. Raise out_ready -> outputs 1,2,3,4,5 in order, no loss or duplicate.
4. Wrap-around with non-power-of-two depth: DEPTH=3, random valid/ready for 200 transfers -> output sequence equals input sequence and occupancy matches the scoreboard every cycle.
5. Flush while full: DEPTH=2, occupancy=2, assert flush for 1 cycle with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1. Flushed and concurrent inputs never appear at the output.
6. Async reset mid-stream: assert rst between clock edges with occupancy=3 -> out_valid=0 and occupancy=0 before the next edge. With PIPE_ELASTIC_PERF_EN, a preceding 7-cycle stall gives backpressure_cycles=7 before reset and 0 after.
